// File: rtl/lvds_echo_responder.sv
// rtl/lvds_echo_responder.sv - LVDS echo link far-end responder: bitslip word alignment, peer handshake, echo FIFO
module lvds_echo_responder #(
    parameter int                DATA_W        = 8,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'hA5,
    parameter logic [DATA_W-1:0] IDLE_WORD     = 8'h00,
    parameter int                LOCK_COUNT    = 16,
    parameter int                SLIP_WAIT     = 4,
    parameter int                FIFO_DEPTH    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_bitslip,
    output logic              rx_align_done,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              tx_align_done,
    output logic [7:0]        led_out
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(2 * DATA_W);
    localparam int HW = $clog2(SLIP_WAIT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [SW-1:0] SLIP_LAST  = SW'(2 * DATA_W - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(SLIP_WAIT - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_TRAIN,
        ST_SLIP_HOLD,
        ST_LOCKED,
        ST_ECHO
    } state_t;

    state_t            state_q, state_d;
    logic [MW-1:0]     match_q, match_d;
    logic [SW-1:0]     slip_q, slip_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              bitslip_q, bitslip_d;
    logic              align_q, align_d;
    logic              lock_err_q, lock_err_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       echo_cnt_q, echo_cnt_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [7:0]        led_q, led_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic rx_hit;
    logic rx_miss;
    logic echo_word;
    logic push;
    logic pop;
    logic flush;
    logic wr_en;
    logic fifo_empty;
    logic fifo_full;
    logic fifo_mode;

    assign rx_hit     = rx_valid && (rx_data == TRAIN_PATTERN);
    assign rx_miss    = rx_valid && (rx_data != TRAIN_PATTERN);
    assign echo_word  = rx_valid && (rx_data != IDLE_WORD) && (rx_data != TRAIN_PATTERN);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    // A peer drop in ECHO flushes the FIFO, so the tx word falls back to the training pattern.
    assign fifo_mode  = (state_q == ST_ECHO) && tx_align_done;

    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        slip_d     = slip_q;
        hold_d     = hold_q;
        bitslip_d  = 1'b0;
        align_d    = align_q;
        lock_err_d = lock_err_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        case (state_q)
            ST_TRAIN: begin
                align_d = 1'b0;
                if (rx_hit) begin
                    if (match_q == MATCH_LAST) begin
                        match_d = '0;
                        align_d = 1'b1;
                        state_d = ST_LOCKED;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end else if (rx_miss) begin
                    match_d   = '0;
                    bitslip_d = 1'b1;
                    hold_d    = '0;
                    state_d   = ST_SLIP_HOLD;
                    if (slip_q == SLIP_LAST) begin
                        slip_d     = '0;
                        lock_err_d = 1'b1;
                    end else begin
                        slip_d = slip_q + 1'b1;
                    end
                end
            end
            ST_SLIP_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_TRAIN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (tx_align_done) begin
                    state_d = ST_ECHO;
                end else begin
                    align_d = 1'b0;
                    state_d = ST_TRAIN;
                end
            end
            ST_ECHO: begin
                if (!tx_align_done) begin
                    align_d = 1'b0;
                    match_d = '0;
                    flush   = 1'b1;
                    state_d = ST_TRAIN;
                end else begin
                    push = echo_word;
                    pop  = tx_ready && !fifo_empty;
                end
            end
            default: begin
                align_d = 1'b0;
                state_d = ST_TRAIN;
            end
        endcase
    end

    always_comb begin
        wr_en      = push && (!fifo_full || pop);
        ovf_d      = ovf_q | (push && fifo_full && !pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        echo_cnt_d = echo_cnt_q;
        tx_d       = tx_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !wr_en) begin
                count_d = count_q - 1'b1;
            end
        end

        if (pop) begin
            echo_cnt_d = echo_cnt_q + 1'b1;
        end

        if (tx_ready) begin
            if (fifo_mode) begin
                tx_d = fifo_empty ? IDLE_WORD : mem_q[rd_ptr_q];
            end else begin
                tx_d = TRAIN_PATTERN;
            end
        end

        led_d = {align_d, tx_align_done, ovf_d, lock_err_d, echo_cnt_d[3:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_TRAIN;
            match_q    <= '0;
            slip_q     <= '0;
            hold_q     <= '0;
            bitslip_q  <= 1'b0;
            align_q    <= 1'b0;
            lock_err_q <= 1'b0;
            ovf_q      <= 1'b0;
            echo_cnt_q <= '0;
            tx_q       <= TRAIN_PATTERN;
            led_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            slip_q     <= slip_d;
            hold_q     <= hold_d;
            bitslip_q  <= bitslip_d;
            align_q    <= align_d;
            lock_err_q <= lock_err_d;
            ovf_q      <= ovf_d;
            echo_cnt_q <= echo_cnt_d;
            tx_q       <= tx_d;
            led_q      <= led_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rx_bitslip    = bitslip_q;
    assign rx_align_done = align_q;
    assign tx_data       = tx_q;
    assign led_out       = led_q;

endmodule
